// File: rtl/archie_wb_pkg.sv
// Shared wishbone constants and the upload reader state type.
package archie_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PREFETCH
    } rd_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [3:0] WB_SEL_ALL     = 4'b1111;

    function automatic logic [15:0] pick_half(input logic [31:0] w, input logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

endpackage

// File: rtl/ram_upload_reader.sv
// Streams an SDRAM window to the HPS upload channel 16 bits at a time,
// holding one cached word and prefetching the next on upper-half reads.
module ram_upload_reader
    import archie_wb_pkg::*;
#(
    parameter logic [25:0] BASE     = 26'h400000,
    parameter int unsigned WIN_BITS = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [25:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        active
);

    localparam int unsigned TW = WIN_BITS - 2;

    rd_state_t     state;
    logic [31:0]   cw;
    logic [TW-1:0] ctag, ptag, pend_tag, tag;
    logic          cval, req_hi, pend_hi, discard, stale, upload_q;
    logic          hit, rd_ev, unused_addr;

    assign tag         = ioctl_addr[WIN_BITS-1:2];
    assign hit         = cval && (ctag == tag);
    assign rd_ev       = ioctl_rd && ioctl_upload;
    assign wb_stb      = wb_cyc;
    assign wb_we       = 1'b0;
    assign wb_cti      = WB_CTI_CLASSIC;
    assign active      = ioctl_upload;
    assign unused_addr = ^{ioctl_addr[0], ioctl_addr};

    function automatic logic [25:0] word_adr(input logic [TW-1:0] t);
        return BASE + 26'({t, 2'b00});
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cw         <= '0;
            ctag       <= '0;
            ptag       <= '0;
            pend_tag   <= '0;
            cval       <= 1'b0;
            req_hi     <= 1'b0;
            pend_hi    <= 1'b0;
            discard    <= 1'b0;
            stale      <= 1'b0;
            upload_q   <= 1'b0;
            ioctl_din  <= '0;
            ioctl_wait <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_sel     <= '0;
            wb_adr     <= '0;
        end else begin
            upload_q <= ioctl_upload;
            if (wb_cyc && wb_ack) begin
                // Follow-up cycles after an ack are deferred one clock so strobes never abut.
                wb_cyc  <= 1'b0;
                wb_sel  <= '0;
                discard <= 1'b0;
                stale   <= 1'b0;
                if (!ioctl_upload) begin
                    state      <= IDLE;
                    ioctl_wait <= 1'b0;
                end else if (discard) begin
                    state  <= FETCH;
                    ptag   <= pend_tag;
                    req_hi <= pend_hi;
                end else if (stale) begin
                    state      <= IDLE;
                    ioctl_wait <= 1'b0;
                end else begin
                    cw   <= wb_dat_i;
                    ctag <= ptag;
                    cval <= 1'b1;
                    if (state == FETCH) begin
                        ioctl_din  <= pick_half(wb_dat_i, req_hi);
                        ioctl_wait <= 1'b0;
                        if (req_hi) begin
                            state <= PREFETCH;
                            ptag  <= ptag + TW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rd_ev && hit) begin
                        ioctl_din <= pick_half(cw, ioctl_addr[1]);
                        state     <= IDLE;
                    end else if (rd_ev && tag == ptag) begin
                        ioctl_din <= pick_half(wb_dat_i, ioctl_addr[1]);
                        if (ioctl_addr[1]) begin
                            state <= PREFETCH;
                            ptag  <= ptag + TW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rd_ev) begin
                        state      <= FETCH;
                        ptag       <= tag;
                        req_hi     <= ioctl_addr[1];
                        ioctl_wait <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            end else if (!ioctl_upload) begin
                if (wb_cyc) begin
                    stale <= 1'b1;
                end else begin
                    state      <= IDLE;
                    ioctl_wait <= 1'b0;
                    discard    <= 1'b0;
                end
            end else if (rd_ev) begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            ioctl_din <= pick_half(cw, ioctl_addr[1]);
                            if (ioctl_addr[1]) begin
                                state  <= PREFETCH;
                                ptag   <= tag + TW'(1);
                                wb_cyc <= 1'b1;
                                wb_sel <= WB_SEL_ALL;
                                wb_adr <= word_adr(tag + TW'(1));
                            end
                        end else begin
                            state      <= FETCH;
                            ptag       <= tag;
                            req_hi     <= ioctl_addr[1];
                            ioctl_wait <= 1'b1;
                            wb_cyc     <= 1'b1;
                            wb_sel     <= WB_SEL_ALL;
                            wb_adr     <= word_adr(tag);
                        end
                    end
                    PREFETCH: begin
                        if (discard) begin
                            state <= PREFETCH;
                        end else if (hit) begin
                            ioctl_din <= pick_half(cw, ioctl_addr[1]);
                        end else if (!wb_cyc || (tag == ptag && !stale)) begin
                            state      <= FETCH;
                            ptag       <= tag;
                            req_hi     <= ioctl_addr[1];
                            ioctl_wait <= 1'b1;
                        end else begin
                            discard    <= 1'b1;
                            pend_tag   <= tag;
                            pend_hi    <= ioctl_addr[1];
                            ioctl_wait <= 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end else if (state != IDLE && !wb_cyc) begin
                wb_cyc <= 1'b1;
                wb_sel <= WB_SEL_ALL;
                wb_adr <= word_adr(ptag);
            end
            if (!(ioctl_upload && upload_q)) cval <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_upload_reader.sv
// Directed bench for ram_upload_reader against a small latency-based SDRAM model.
module tb_ram_upload_reader;

    localparam int unsigned LAT = 5;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [25:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        active;

    logic        fixed_mode;
    logic [31:0] fixed_word;
    int unsigned cnt;
    logic [25:0] adr_log[$];

    int n_checks = 0;
    int n_errors = 0;

    ram_upload_reader #(.BASE(26'h400000), .WIN_BITS(24)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .active(active)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: ack LAT cycles after cyc is first seen; data is the word index unless fixed.
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wb_ack   <= 1'b0;
            wb_dat_i <= '0;
            cnt      <= 0;
        end else if (wb_ack) begin
            wb_ack <= 1'b0;
            if (wb_cyc) adr_log.push_back(wb_adr);
        end else if (wb_cyc) begin
            if (cnt == LAT - 1) begin
                wb_ack   <= 1'b1;
                wb_dat_i <= fixed_mode ? fixed_word
                                       : {8'h00, 24'((wb_adr - 26'h400000) >> 2)};
                cnt      <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_rd(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic host_read(input string tag, input logic [24:0] a,
                             input logic [15:0] exp, input logic exp_wait);
        logic last_ack;
        last_ack = 1'b0;
        do_rd(a);
        check({tag, "_wait"}, 32'(ioctl_wait), 32'(exp_wait));
        for (int i = 0; i < 100 && ioctl_wait; i++) begin
            last_ack = wb_ack;
            @(negedge clk_sys);
        end
        check({tag, "_wait_end"}, 32'(ioctl_wait), 32'd0);
        if (exp_wait) check({tag, "_ack_before_drop"}, 32'(last_ack), 32'd1);
        check({tag, "_din"}, 32'(ioctl_din), 32'(exp));
    endtask

    task automatic new_session();
        ioctl_upload = 1'b0;
        idle(12);
        ioctl_upload = 1'b1;
        idle(1);
    endtask

    initial begin
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        fixed_mode   = 1'b0;
        fixed_word   = '0;
        idle(3);
        check("rst_cyc",  32'(wb_cyc), 32'd0);
        check("rst_stb",  32'(wb_stb), 32'd0);
        check("rst_sel",  32'(wb_sel), 32'd0);
        check("rst_adr",  32'(wb_adr), 32'd0);
        check("rst_din",  32'(ioctl_din), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_cti",  32'(wb_cti), 32'd0);
        check("rst_we",   32'(wb_we), 32'd0);
        reset = 1'b0;
        idle(2);

        // Cold read with fixed data
        fixed_mode   = 1'b1;
        fixed_word   = 32'hDEADBEEF;
        ioctl_upload = 1'b1;
        idle(1);
        check("active", 32'(active), 32'd1);
        do_rd(25'h0);
        check("cold_cyc", 32'(wb_cyc), 32'd1);
        check("cold_sel", 32'(wb_sel), 32'hF);
        check("cold_adr", 32'(wb_adr), 32'h400000);
        check("cold_wait", 32'(ioctl_wait), 32'd1);
        for (int i = 0; i < 100 && ioctl_wait; i++) @(negedge clk_sys);
        check("cold_din", 32'(ioctl_din), 32'hBEEF);
        fixed_mode = 1'b0;

        // Linear stream with word-index data
        new_session();
        host_read("lin0", 25'h0, 16'h0000, 1'b1);
        do_rd(25'h2);
        check("lin2_wait", 32'(ioctl_wait), 32'd0);
        check("lin2_din", 32'(ioctl_din), 32'h0000);
        check("lin2_pf_cyc", 32'(wb_cyc), 32'd1);
        check("lin2_pf_adr", 32'(wb_adr), 32'h400004);
        idle(8);
        host_read("lin4", 25'h4, 16'h0001, 1'b0);
        host_read("lin6", 25'h6, 16'h0000, 1'b0);
        idle(10);

        // Jump while the next-word prefetch is in flight
        new_session();
        host_read("jmp0", 25'h0, 16'h0000, 1'b1);
        do_rd(25'h2);
        check("jmp2_din", 32'(ioctl_din), 32'h0000);
        adr_log.delete();
        host_read("jmp1000", 25'h1000, 16'h0400, 1'b1);
        check("jmp_log_n", 32'(adr_log.size()), 32'd2);
        if (adr_log.size() == 2) begin
            check("jmp_log0", 32'(adr_log[0]), 32'h400004);
            check("jmp_log1", 32'(adr_log[1]), 32'h401000);
        end
        host_read("jmp4_refetch", 25'h4, 16'h0001, 1'b1);
        idle(4);

        // Upper half at the top of the window: prefetch wraps to the base
        host_read("wrap", 25'hFFFFFE, 16'h003F, 1'b1);
        for (int i = 0; i < 10 && !wb_cyc; i++) @(negedge clk_sys);
        check("wrap_pf_cyc", 32'(wb_cyc), 32'd1);
        check("wrap_pf_adr", 32'(wb_adr), 32'h400000);
        idle(10);

        // Upload drops while a demand fetch is in flight
        new_session();
        do_rd(25'h20);
        check("drop_wait_hi", 32'(ioctl_wait), 32'd1);
        ioctl_upload = 1'b0;
        idle(2);
        check("drop_cyc_held", 32'(wb_cyc), 32'd1);
        check("drop_active", 32'(active), 32'd0);
        for (int i = 0; i < 100 && ioctl_wait; i++) @(negedge clk_sys);
        check("drop_wait_lo", 32'(ioctl_wait), 32'd0);
        check("drop_cyc_lo", 32'(wb_cyc), 32'd0);
        idle(4);
        ioctl_upload = 1'b1;
        idle(1);
        host_read("drop_refetch", 25'h20, 16'h0008, 1'b1);

        // Asynchronous reset mid-cycle
        do_rd(25'h40);
        check("ar_cyc_before", 32'(wb_cyc), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_cyc", 32'(wb_cyc), 32'd0);
        check("ar_stb", 32'(wb_stb), 32'd0);
        check("ar_wait", 32'(ioctl_wait), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(2);
        host_read("ar_refetch", 25'h40, 16'h0010, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
